// File: rtl/fp_pkg.sv
// fp_pkg: shared types, flag indices and helpers for the sequential FP multiplier.
package fp_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MULT,
    S_NORM,
    S_ROUND,
    S_DONE
  } fpm_state_t;
  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_t;
  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction
endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: splits an FP word into sign/exponent/significand and classifies it (subnormals flush to zero).
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W:0]       sig_o,
  output fp_class_t            cls_o
);
  logic exp_zero, exp_ones, frac_zero;
  assign sign_o    = x_i[EXP_W+MAN_W];
  assign exp_o     = x_i[MAN_W +: EXP_W];
  assign exp_zero  = exp_o == '0;
  assign exp_ones  = &exp_o;
  assign frac_zero = x_i[MAN_W-1:0] == '0;
  assign sig_o     = exp_zero ? '0 : {1'b1, x_i[MAN_W-1:0]};
  assign cls_o     = exp_zero ? FP_ZERO : !exp_ones ? FP_NORMAL : frac_zero ? FP_INF : FP_NAN;
endmodule

// File: rtl/fp_mult_seq.sv
// fp_mult_seq: multi-cycle parametrised FP multiplier with start/done handshake.
// Define FP_MULT_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_mult_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] p,
  output logic [3:0]           flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]  QNAN  = W'(fp_qnan(EXP_W, MAN_W));

  fpm_state_t       state_q, state_d;
  logic [W-1:0]     a_q, b_q, p_q, p_d;
  logic [3:0]       flags_q, flags_d;
  logic             sign_q, g_q, s_q, g_n, s_n, msb, inc, accept;
  logic [EW-1:0]    e_q, e_r;
  logic [MAN_W:0]   siga_q, sigb_q, frac_r;
  logic [MAN_W-1:0] frac_q, frac_n;
  logic [PW-1:0]    prod_q;
  fp_class_t        ca_q, cb_q, ua_cls, ub_cls;
  logic             ua_sign, ub_sign;
  logic [EXP_W-1:0] ua_exp, ub_exp;
  logic [MAN_W:0]   ua_sig, ub_sig;
  logic             nan_in, inf_zero, any_inf, any_zero, ovf, udf;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .x_i(a_q), .sign_o(ua_sign), .exp_o(ua_exp), .sig_o(ua_sig), .cls_o(ua_cls)
  );
  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .x_i(b_q), .sign_o(ub_sign), .exp_o(ub_exp), .sig_o(ub_sig), .cls_o(ub_cls)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = start ? S_UNPACK : S_IDLE;
      S_UNPACK:       state_d = S_MULT;
      S_MULT:         state_d = S_NORM;
      S_NORM:         state_d = S_ROUND;
      S_ROUND:        state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  assign accept = (state_q == S_IDLE || state_q == S_DONE) && start;
  assign busy   = state_q inside {S_UNPACK, S_MULT, S_NORM, S_ROUND};
  assign done   = state_q == S_DONE;
  assign p      = p_q;
  assign flags  = flags_q;

  // Normal significands lie in [1,2), so the product lies in [1,4): at most one bit of renormalisation.
  assign msb    = prod_q[PW-1];
  assign frac_n = msb ? prod_q[PW-2 -: MAN_W] : prod_q[PW-3 -: MAN_W];
  assign g_n    = msb ? prod_q[MAN_W] : prod_q[MAN_W-1];
  assign s_n    = msb ? |prod_q[MAN_W-1:0] : |prod_q[MAN_W-2:0];

`ifdef FP_MULT_RNE_EN
  assign inc = g_q & (s_q | frac_q[0]);
`else
  assign inc = 1'b0;
`endif
  assign frac_r = {1'b0, frac_q} + (MAN_W + 1)'(inc);
  assign e_r    = e_q + EW'(frac_r[MAN_W]);
  assign ovf    = !e_r[EW-1] && e_r >= E_MAX;
  assign udf    = e_r[EW-1] || e_r == '0;

  assign nan_in   = ca_q == FP_NAN || cb_q == FP_NAN;
  assign inf_zero = (ca_q == FP_INF && cb_q == FP_ZERO) || (ca_q == FP_ZERO && cb_q == FP_INF);
  assign any_inf  = ca_q == FP_INF || cb_q == FP_INF;
  assign any_zero = ca_q == FP_ZERO || cb_q == FP_ZERO;

  always_comb begin
    p_d = {sign_q, e_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
    flags_d = '0;
    flags_d[FLAG_INEXACT] = g_q | s_q;
    if (nan_in || inf_zero) begin
      p_d = QNAN;
      flags_d = '0;
      flags_d[FLAG_INVALID] = inf_zero;
    end else if (any_inf) begin
      p_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = '0;
    end else if (any_zero) begin
      p_d = {sign_q, {(W - 1){1'b0}}};
      flags_d = '0;
    end else if (ovf) begin
      p_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d[FLAG_OVERFLOW] = 1'b1;
      flags_d[FLAG_INEXACT] = 1'b1;
    end else if (udf) begin
      p_d = {sign_q, {(W - 1){1'b0}}};
      flags_d[FLAG_UNDERFLOW] = 1'b1;
      flags_d[FLAG_INEXACT] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q <= a;
        b_q <= b;
      end
      if (state_q == S_UNPACK) begin
        sign_q <= ua_sign ^ ub_sign;
        e_q    <= EW'(ua_exp) + EW'(ub_exp) - BIAS;
        siga_q <= ua_sig;
        sigb_q <= ub_sig;
        ca_q   <= ua_cls;
        cb_q   <= ub_cls;
      end
      if (state_q == S_MULT) prod_q <= PW'(siga_q) * PW'(sigb_q);
      if (state_q == S_NORM) begin
        frac_q <= frac_n;
        g_q    <= g_n;
        s_q    <= s_n;
        e_q    <= e_q + EW'(msb);
      end
      if (state_q == S_ROUND) begin
        p_q     <= p_d;
        flags_q <= flags_d;
      end
    end
  end
endmodule

// File: tb/tb_fp_mult_seq.sv
// tb_fp_mult_seq: directed and random checks of fp_mult_seq (binary32 and binary16 instances) against an arithmetic model.
module tb_fp_mult_seq;
  logic        clk = 0, rst = 1;
  logic        start = 0, start_h = 0;
  logic [31:0] a = 0, b = 0, p;
  logic [15:0] a_h = 0, b_h = 0, p_h;
  logic        busy, done, busy_h, done_h;
  logic [3:0]  flags, flags_h;
  int          n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  fp_mult_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .p(p), .flags(flags)
  );
  fp_mult_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .start(start_h), .a(a_h), .b(b_h),
    .busy(busy_h), .done(done_h), .p(p_h), .flags(flags_h)
  );

  // Exact integer product of the significands, scaled and rounded by comparing the discarded remainder to one half.
  function automatic logic [67:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input int ew, input int mw);
    int emax, bias, ea, eb, k, e;
    longint unsigned mmask, fa, fb, sgn, prod, q, rem, half, inf_v, zro_v, qnan_v;
    bit za, zb, ia, ib, na, nb;
    emax   = (1 << ew) - 1;
    bias   = (1 << (ew - 1)) - 1;
    mmask  = (64'd1 << mw) - 1;
    ea     = int'(x >> mw) & emax;
    eb     = int'(y >> mw) & emax;
    fa     = longint'(x) & mmask;
    fb     = longint'(y) & mmask;
    sgn    = longint'(x[ew+mw] ^ y[ew+mw]);
    inf_v  = (sgn << (ew + mw)) | (longint'(emax) << mw);
    zro_v  = sgn << (ew + mw);
    qnan_v = (longint'(emax) << mw) | (64'd1 << (mw - 1));
    za = ea == 0; zb = eb == 0;
    ia = ea == emax && fa == 0; ib = eb == emax && fb == 0;
    na = ea == emax && fa != 0; nb = eb == emax && fb != 0;
    if (na || nb || (ia && zb) || (za && ib)) return {((ia && zb) || (za && ib)), 3'b000, qnan_v};
    if (ia || ib) return {4'b0000, inf_v};
    if (za || zb) return {4'b0000, zro_v};
    prod = ((64'd1 << mw) | fa) * ((64'd1 << mw) | fb);
    k    = (prod >= (64'd1 << (2 * mw + 1))) ? mw + 1 : mw;
    q    = prod >> k;
    rem  = prod & ((64'd1 << k) - 1);
    half = 64'd1 << (k - 1);
    e    = ea + eb - bias + k - mw;
`ifdef FP_MULT_RNE_EN
    if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
    if ((q >> (mw + 1)) != 0) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= emax) return {4'b0101, inf_v};
    if (e <= 0) return {4'b0011, zro_v};
    return {3'b000, rem != 0, (sgn << (ew + mw)) | (longint'(e) << mw) | (q & mmask)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One complete transaction on either instance, with latency, result, flags and pulse-width checks.
  task automatic op(input bit hf, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] exp_p, input logic [3:0] exp_f, input string tag);
    int cyc;
    @(negedge clk);
    if (hf) begin
      start_h = 1; a_h = x[15:0]; b_h = y[15:0];
    end else begin
      start = 1; a = x; b = y;
    end
    @(negedge clk);
    start = 0; start_h = 0;
    a = $urandom; b = $urandom; a_h = 16'($urandom); b_h = 16'($urandom);
    cyc = 1;
    chk({tag, "_busy"}, hf ? busy_h : busy, 1);
    while (!(hf ? done_h : done) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 5);
    chk({tag, "_p"}, hf ? {16'h0, p_h} : p, exp_p);
    chk({tag, "_flags"}, hf ? flags_h : flags, exp_f);
    @(negedge clk);
    chk({tag, "_done_pulse"}, hf ? done_h : done, 0);
  endtask

  initial begin
    logic [67:0] r;
    logic [31:0] x, y;
    logic [31:0] ba[4], bb[4];
    int cyc, seen;

    repeat (2) @(negedge clk);
    chk("reset_p", p, 0);
    chk("reset_flags", flags, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    rst = 0;

    op(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, "mul_1p5x2");
    op(1, 32'h00003C00, 32'h0000C000, 32'h0000C000, 4'b0000, "half_1xm2");
    op(0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, "inf_x_zero");
    op(0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, "ninf_x_2");
    op(0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, "nan_x_1");
    op(0, 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, "nzero_x_1");
    op(0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, "overflow");
    op(0, 32'h80800000, 32'h00800000, 32'h80000000, 4'b0011, "underflow");
`ifdef FP_MULT_RNE_EN
    op(0, 32'h3FC00001, 32'h3FC00001, 32'h40100002, 4'b0001, "round_rne");
`else
    op(0, 32'h3FC00001, 32'h3FC00001, 32'h40100001, 4'b0001, "round_trunc");
`endif

    for (int i = 0; i < 40; i++) begin
      x = $urandom; y = $urandom;
      if (i % 4 != 0) begin
        x[30:23] = 8'($urandom_range(60, 200));
        y[30:23] = 8'($urandom_range(60, 200));
      end
      r = ref_mul(x, y, 8, 23);
      op(0, x, y, r[31:0], r[67:64], "rand32");
    end
    for (int i = 0; i < 20; i++) begin
      x = {16'h0, 16'($urandom)}; y = {16'h0, 16'($urandom)};
      if (i % 4 != 0) begin
        x[14:10] = 5'($urandom_range(6, 24));
        y[14:10] = 5'($urandom_range(6, 24));
      end
      r = ref_mul(x, y, 5, 10);
      op(1, x, y, r[31:0], r[67:64], "rand16");
    end

    // start held high: a new operation is accepted from every DONE cycle.
    ba[0] = 32'h3FC00000; bb[0] = 32'h40000000;
    ba[1] = 32'hC0400000; bb[1] = 32'h3F000000;
    ba[2] = 32'h3FC00000; bb[2] = 32'h40000000;
    ba[3] = 32'hC0400000; bb[3] = 32'h3F000000;
    @(negedge clk);
    start = 1; a = ba[0]; b = bb[0];
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) begin a = 32'h12345678; b = 32'h9ABCDEF0; end
      end while (!done && cyc < 20);
      r = ref_mul(ba[i], bb[i], 8, 23);
      chk("b2b_period", cyc, 5);
      chk("b2b_p", p, r[31:0]);
      chk("b2b_flags", flags, r[67:64]);
      if (i < 3) begin a = ba[i+1]; b = bb[i+1]; end else start = 0;
    end
    @(negedge clk);
    chk("b2b_end_done", done, 0);

    // start while busy is ignored and not queued.
    @(negedge clk);
    start = 1; a = 32'h3FC00000; b = 32'h40000000;
    @(negedge clk);
    a = 32'h7F800000; b = 32'h00000000;
    @(negedge clk);
    start = 0;
    cyc = 2;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy_ign_latency", cyc, 5);
    chk("busy_ign_p", p, 32'h40400000);
    chk("busy_ign_flags", flags, 0);
    @(negedge clk);
    chk("busy_ign_no_queue_done", done, 0);
    chk("busy_ign_no_queue_busy", busy, 0);

    // Reset during MULT aborts the operation.
    @(negedge clk);
    start = 1; a = 32'h40000000; b = 32'h40000000;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("abort_busy_mult", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_p", p, 0);
    chk("abort_flags", flags, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    op(0, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
